// File: rtl/mid3_filter_ctrl_if.sv
// Sample-stream and result signals between the capture logic, the trimmed-mean
// controller and the display/position logic.
interface mid3_filter_ctrl_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       flush;
  logic [7:0] filtered_out;
  logic       out_valid;
  logic       busy;
  logic       window_full;

  modport master (
    output sample_in, sample_valid, flush,
    input  filtered_out, out_valid, busy, window_full
  );

  modport slave (
    input  sample_in, sample_valid, flush,
    output filtered_out, out_valid, busy, window_full
  );
endinterface

// File: rtl/mid3_filter_ctrl.sv
// Sliding 5-sample window feeding a middle-three sorter, followed by a serial
// divide-by-3 that produces the trimmed mean of the three middle samples.
module mid3_of5 (
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  input  logic [7:0] data4,
  input  logic [7:0] data5,
  output logic [7:0] mid1,
  output logic [7:0] mid2,
  output logic [7:0] mid3
);
  logic [7:0] s [5];
  logic [7:0] tmp;

  always_comb begin
    s[0] = data1;
    s[1] = data2;
    s[2] = data3;
    s[3] = data4;
    s[4] = data5;
    tmp  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4 - i; j++) begin
        if (s[j] > s[j+1]) begin
          tmp    = s[j];
          s[j]   = s[j+1];
          s[j+1] = tmp;
        end
      end
    end
    mid1 = s[1];
    mid2 = s[2];
    mid3 = s[3];
  end
endmodule

module mid3_filter_ctrl (
  input  logic                 clock,
  input  logic                 reset,
  mid3_filter_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DIV, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] win_q [5];
  logic [7:0] win_d [5];
  logic [2:0] wp_q, wp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic [9:0] sum_q, sum_d;
  logic [1:0] rem_q, rem_d;
  logic [3:0] step_q, step_d;
  logic [7:0] filtered_out_q, filtered_out_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, window_full_q;

  logic [7:0] mid1, mid2, mid3;
  logic [2:0] trial, diff;
  logic       ge3, accept;
  logic [9:0] shifted;

  mid3_of5 u_sort (
    .data1 (win_q[0]),
    .data2 (win_q[1]),
    .data3 (win_q[2]),
    .data4 (win_q[3]),
    .data5 (win_q[4]),
    .mid1  (mid1),
    .mid2  (mid2),
    .mid3  (mid3)
  );

  // Restoring divide step: sum_q doubles as the dividend shifter, quotient
  // bits enter at the LSB as dividend bits leave at the MSB.
  assign trial   = {rem_q, sum_q[9]};
  assign ge3     = (trial >= 3'd3);
  assign diff    = trial - 3'd3;
  assign shifted = {sum_q[8:0], ge3};
  assign accept  = bus.sample_valid && !bus.flush;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    win_d          = win_q;
    wp_d           = wp_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    sum_d          = sum_q;
    rem_d          = rem_q;
    step_d         = step_q;
    filtered_out_d = filtered_out_q;
    out_valid_d    = 1'b0;

    if (accept) begin
      win_d[wp_q] = bus.sample_in;
      wp_d        = (wp_q == 3'd4) ? 3'd0 : wp_q + 3'd1;
      if (cnt_q != 3'd5) cnt_d = cnt_q + 3'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && cnt_d == 3'd5) state_d = CAPTURE;
      end
      CAPTURE: begin
        sum_d   = {2'b00, mid1} + {2'b00, mid2} + {2'b00, mid3};
        rem_d   = 2'd0;
        step_d  = 4'd0;
        state_d = DIV;
        if (accept) pending_d = 1'b1;
      end
      DIV: begin
        sum_d  = shifted;
        rem_d  = ge3 ? diff[1:0] : trial[1:0];
        step_d = step_q + 4'd1;
        if (step_q == 4'd9) begin
          state_d        = DONE;
          filtered_out_d = shifted[7:0];
          out_valid_d    = 1'b1;
        end
        if (accept) pending_d = 1'b1;
      end
      DONE: begin
        // A sample landing in DONE is already in the window for the rerun.
        if (pending_q || accept) begin
          state_d   = CAPTURE;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d        = IDLE;
      cnt_d          = 3'd0;
      wp_d           = 3'd0;
      pending_d      = 1'b0;
      out_valid_d    = 1'b0;
      filtered_out_d = filtered_out_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      // NOTE: the window is a small register file, not RAM, so it is cleared on reset.
      for (int i = 0; i < 5; i++) win_q[i] <= '0;
      wp_q           <= '0;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      sum_q          <= '0;
      rem_q          <= '0;
      step_q         <= '0;
      filtered_out_q <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      window_full_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_q          <= win_d;
      wp_q           <= wp_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      sum_q          <= sum_d;
      rem_q          <= rem_d;
      step_q         <= step_d;
      filtered_out_q <= filtered_out_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= (state_d != IDLE);
      window_full_q  <= (cnt_d == 3'd5);
    end
  end

  assign bus.filtered_out = filtered_out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.window_full  = window_full_q;
endmodule

// File: tb/tb_mid3_filter_ctrl.sv
// Directed scoreboard bench for mid3_filter_ctrl: stimulus pushes expected
// results with their due cycle, an independent monitor pops on out_valid.
module tb_mid3_filter_ctrl;
  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t sb [$];

  mid3_filter_ctrl_if bus ();

  mid3_filter_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input logic [7:0] val, input int due);
    exp_t e;
    e.val = val;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] fo, input logic ov,
                               input logic bz, input logic wf);
    check({tag, "_filtered_out"}, bus.filtered_out, fo);
    check({tag, "_out_valid"}, bus.out_valid, ov);
    check({tag, "_busy"}, bus.busy, bz);
    check({tag, "_window_full"}, bus.window_full, wf);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation in value and cycle.
  always @(negedge clock) begin
    if (!reset && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got pulse with %0d, expected none (cycle %0d)",
                 bus.filtered_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_value", bus.filtered_out, e.val);
        check("out_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    cyc              = 0;
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.flush        = 1'b0;
    idle(3);
    reset = 1'b0;
    check_outputs("reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // 1..5: only the fifth strobe starts a computation.
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    check("four_samples_window_full", bus.window_full, 1'b0);
    check("four_samples_busy", bus.busy, 1'b0);
    expect_out(8'd3, cyc + 12);
    send(8'd5);
    check("capture_busy", bus.busy, 1'b1);
    check("capture_window_full", bus.window_full, 1'b1);
    idle(14);
    check("after_first_busy", bus.busy, 1'b0);
    check("after_first_hold", bus.filtered_out, 8'd3);

    // 6 overwrites slot 0: window 6,2,3,4,5 -> (3+4+5)/3.
    expect_out(8'd4, cyc + 12);
    send(8'd6);
    idle(14);

    // Outlier rejection and extremes.
    do_flush();
    check("flush_window_full", bus.window_full, 1'b0);
    send(8'd10); send(8'd10); send(8'd200); send(8'd10);
    expect_out(8'd10, cyc + 12);
    send(8'd10);
    idle(14);

    do_flush();
    send(8'd0); send(8'd0); send(8'd255); send(8'd255);
    expect_out(8'd170, cyc + 12);
    send(8'd255);
    idle(14);

    do_flush();
    repeat (4) send(8'd255);
    expect_out(8'd255, cyc + 12);
    send(8'd255);
    idle(14);

    // Two strobes during DIV coalesce into one rerun on window 50,60,3,4,5.
    do_flush();
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    t0 = cyc;
    expect_out(8'd3, t0 + 12);
    send(8'd5);
    idle(3);
    send(8'd50);
    send(8'd60);
    expect_out(8'd19, t0 + 24);
    idle(26);
    check("coalesce_busy", bus.busy, 1'b0);

    // Flush mid-DIV: run aborted, result holds, refill needs five new samples.
    send(8'd7);
    idle(4);
    check("pre_flush_busy", bus.busy, 1'b1);
    do_flush();
    check_outputs("flush_div", 8'd19, 1'b0, 1'b0, 1'b0);
    idle(14);
    send(8'd100); send(8'd110); send(8'd120); send(8'd130);
    idle(14);
    check("refill_four_window_full", bus.window_full, 1'b0);
    expect_out(8'd120, cyc + 12);
    send(8'd140);
    idle(14);

    // Reset during DIV clears every output the next cycle.
    send(8'd1);
    idle(4);
    check("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b1;
    idle(1);
    check_outputs("reset_div", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(14);

    // Flush together with a sample: the sample must not count toward the window.
    bus.flush        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 8'd9;
    idle(1);
    bus.flush        = 1'b0;
    bus.sample_valid = 1'b0;
    send(8'd20); send(8'd30); send(8'd40); send(8'd50);
    idle(2);
    check("dropped_sample_window_full", bus.window_full, 1'b0);
    check("dropped_sample_busy", bus.busy, 1'b0);
    expect_out(8'd40, cyc + 12);
    send(8'd60);

    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    idle(2);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
